// File: rtl/decoder_seq_pkg.sv
// Shared types for the decoder select sequencer.
// Holds sweep modes, FSM states and the code lookup.
package decoder_seq_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Select code for position idx of a sweep in the given mode.
  // The reserved mode 11 sweeps like up.
  function automatic logic [1:0] code_of(
    input logic [1:0] mode,
    input logic [1:0] idx
  );
    logic [1:0] code;
    code = idx;
    unique case (mode)
      MODE_DOWN: code = ~idx;
      MODE_GRAY: code = {idx[1], idx[1] ^ idx[0]};
      default:   code = idx;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/decoder_select_sequencer_dwell_timer.sv
// Dwell counter for the select sequencer.
// Counts 0..limit while enabled; tc marks the last cycle.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] limit,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt;

  // limit is dwell_eff-1, so the full range never overflows.
  assign tc = enable && (cnt == limit);

  // Count up and wrap to zero on the terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == limit) cnt <= '0;
      else              cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_select_sequencer.sv
// Scan source for the 2-to-4 decoder select lines.
// Sweeps all four codes, each held for a latched dwell.
module decoder_select_sequencer
  import decoder_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               continuous,
  output logic               s_1,
  output logic               s_0,
  output logic               valid,
  output logic               step,
  output logic               done,
  output logic               busy
);

  state_t             state;
  logic [1:0]         idx;
  logic [1:0]         mode_q;
  logic [DWELL_W-1:0] limit_q;
  logic               cont_q;
  logic               tc;
  logic               run;
  logic               clear;
  logic [1:0]         nxt;

  assign run   = (state == ST_RUN) && !stop;
  assign clear = (state == ST_IDLE) || stop;
  assign nxt   = idx + 2'd1;

  dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .enable(run),
    .limit (limit_q),
    .tc    (tc)
  );

  // Sweep FSM with index and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= 2'd0;
      mode_q  <= MODE_UP;
      limit_q <= '0;
      cont_q  <= 1'b0;
      {s_1, s_0} <= 2'b00;
      valid   <= 1'b0;
      step    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state   <= ST_RUN;
            idx     <= 2'd0;
            mode_q  <= mode;
            limit_q <= (dwell == '0) ? '0 : dwell - 1'b1;
            cont_q  <= continuous;
            {s_1, s_0} <= code_of(mode, 2'd0);
            valid   <= 1'b1;
            busy    <= 1'b1;
            step    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            idx   <= 2'd0;
            {s_1, s_0} <= 2'b00;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (tc) begin
            if (idx != 2'd3) begin
              idx  <= nxt;
              {s_1, s_0} <= code_of(mode_q, nxt);
              step <= 1'b1;
            end else if (cont_q) begin
              idx  <= 2'd0;
              {s_1, s_0} <= code_of(mode_q, 2'd0);
              step <= 1'b1;
              done <= 1'b1;
            end else begin
              state <= ST_IDLE;
              idx   <= 2'd0;
              {s_1, s_0} <= 2'b00;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Bench for decoder_select_sequencer.
// Directed steps then random traffic against a timeline model.
module tb_decoder_select_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [DW-1:0] dwell;
  logic          continuous;
  logic          s_1, s_0, valid, step, done, busy;

  int checks = 0;
  int errors = 0;

  // Model: a sweep is a timeline t = 0 .. 4*de-1 since first code.
  logic [1:0] ord [4][4] = '{
    '{2'd0, 2'd1, 2'd2, 2'd3},
    '{2'd3, 2'd2, 2'd1, 2'd0},
    '{2'd0, 2'd1, 2'd3, 2'd2},
    '{2'd0, 2'd1, 2'd2, 2'd3}
  };
  bit act = 0;
  int t = 0;
  int m_de = 1;
  int m_mode = 0;
  bit m_cont = 0;
  bit m_done = 0;

  always #5 clk = ~clk;

  decoder_select_sequencer #(
    .DWELL_W(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dwell     (dwell),
    .continuous(continuous),
    .s_1       (s_1),
    .s_0       (s_0),
    .valid     (valid),
    .step      (step),
    .done      (done),
    .busy      (busy)
  );

  task automatic model_edge();
    m_done = 0;
    if (!rst_n) begin
      act = 0;
    end else if (act) begin
      if (stop) begin
        act = 0;
      end else begin
        t++;
        if (t == 4 * m_de) begin
          m_done = 1;
          if (m_cont) t = 0;
          else act = 0;
        end
      end
    end else if (start && !stop) begin
      act = 1;
      t = 0;
      m_mode = int'(mode);
      m_de = (dwell == 0) ? 1 : int'(dwell);
      m_cont = continuous;
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] es;
    logic [3:0] ef;
    es = act ? ord[m_mode][t / m_de] : 2'd0;
    ef = {act, act && (t % m_de == 0), m_done, act};
    checks++;
    assert ({s_1, s_0} === es) else begin
      errors++;
      $error("FAIL %s code: observed %b expected %b", tag, {s_1, s_0}, es);
    end
    checks++;
    assert ({valid, step, done, busy} === ef) else begin
      errors++;
      $error("FAIL %s flags(v,st,d,b): observed %b expected %b",
             tag, {valid, step, done, busy}, ef);
    end
  endtask

  task automatic tick(input bit st, input bit sp, input logic [1:0] md,
                      input logic [DW-1:0] dw, input bit ct,
                      input string tag);
    start = st;
    stop = sp;
    mode = md;
    dwell = dw;
    continuous = ct;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_n(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(0, 0, 2'd0, 8'd0, 0, tag);
  endtask

  initial begin
    rst_n = 0;
    start = 0; stop = 0; mode = 0; dwell = 0; continuous = 0;
    #2;
    for (int i = 0; i < 3; i++) tick(1, 0, 2'd0, 8'd3, 0, "reset");
    rst_n = 1;
    idle_n(3, "post_reset");

    tick(1, 0, 2'd0, 8'd3, 0, "up_start");
    for (int i = 0; i < 14; i++) tick(0, 0, 2'd0, 8'd3, 0, "up");
    checks++;
    assert (!valid && !busy) else begin
      errors++;
      $error("FAIL up_end: observed valid=%b expected 0", valid);
    end

    tick(1, 0, 2'd2, 8'd0, 0, "gray_start");
    for (int i = 0; i < 6; i++) tick(0, 0, 2'd2, 8'd0, 0, "gray0");

    tick(1, 0, 2'd1, 8'd2, 1, "cont_start");
    for (int i = 1; i < 11; i++) tick(0, 0, 2'd1, 8'd2, 1, "cont");
    tick(0, 1, 2'd1, 8'd2, 1, "cont_stop");
    idle_n(3, "cont_idle");

    tick(1, 1, 2'd0, 8'd1, 0, "start_stop");
    idle_n(2, "start_stop_idle");

    tick(1, 0, 2'd0, 8'd2, 0, "tc_start");
    for (int i = 1; i < 8; i++) tick(1, 0, 2'd3, 8'd7, 1, "run_start_chg");
    tick(0, 1, 2'd0, 8'd2, 0, "tc_stop");
    idle_n(3, "tc_idle");

    tick(1, 0, 2'd0, 8'd255, 0, "max_start");
    for (int i = 0; i < 1025; i++) tick(0, 0, 2'd1, 8'd1, 0, "max");

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(199) != 0);
      tick(($urandom_range(7) == 0), ($urandom_range(63) == 0),
           2'($urandom_range(3)), 8'($urandom_range(5)),
           1'($urandom_range(1)), "random");
    end
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_select_sequencer.md
Name: decoder_select_sequencer

Overview:
Generates the 2-bit select code (s_1, s_0) that feeds the 2-to-4 decoder stage directly downstream.
- Sweeps all four codes in a chosen order and holds each code for a programmable number of cycles.
- Signals a completed sweep to the surrounding control logic.
- Replaces hand-written stimulus with a synthesizable scan source, for example for LED or row-select scanning.

Parameters:
DWELL_W, 8, width of the dwell input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request to begin a sweep; sampled only in IDLE.
- stop  input  1  abort request; sampled in every state.
- mode  input  2  sweep order: 00 up, 01 down, 10 gray, 11 reserved (behaves as up).
- dwell  input  DWELL_W  number of cycles each code is held; a value of 0 is treated as 1.
- continuous  input  1  when 1, restart the sweep automatically after the last code.
- s_1  output  1  select MSB to the decoder.
- s_0  output  1  select LSB to the decoder.
- valid  output  1  the select code is being driven by an active sweep.
- step  output  1  one-cycle pulse on every cycle the code is first presented.
- done  output  1  one-cycle pulse when a sweep completes.
- busy  output  1  the FSM is in RUN.

Behaviour:
Reset
- rst_n=0 at a rising edge puts the FSM in IDLE.
- s_1, s_0, valid, step, done and busy all go to 0.
- The dwell counter and the index are cleared.
- Reset mid-sweep aborts the sweep with no done pulse.

Outputs and sampling
- All outputs are registered.
- mode, dwell and continuous are latched on the start edge; later changes are ignored until the next start from IDLE.

Code order, indexed by idx 0..3
- up: 00, 01, 10, 11
- down: 11, 10, 01, 00
- gray: 00, 01, 11, 10

FSM states: IDLE, RUN.

IDLE
- Outputs s=00, valid=0, busy=0.
- start=1 and stop=0 at edge N: in cycle N+1, state=RUN, idx=0, the first code is on s, valid=1, busy=1, step=1.
- start and stop both 1: stop wins and the FSM stays in IDLE.

RUN
- dwell_eff = max(dwell, 1). Each code is held exactly dwell_eff cycles.
- The dwell counter counts 0..dwell_eff-1.
- On the terminal count with idx<3: idx increments and step pulses with the new code.
- On the terminal count with idx=3 and continuous=0:
  - Next cycle: state=IDLE, done=1 for one cycle, valid=0, busy=0, s=00.
- On the terminal count with idx=3 and continuous=1:
  - Next cycle: idx wraps to 0, the first code is presented, done=1 and step=1 in that same cycle, and the FSM stays in RUN.
- start while in RUN is ignored.

Stop
- stop=1 in RUN at any cycle: next cycle is IDLE with s=00 and valid=0. There is no done pulse.
- Stop takes priority over the terminal-count advance in the same cycle.

Counter arithmetic
- The dwell counter is DWELL_W bits and unsigned.
- dwell = 2^DWELL_W-1 must work without overflow, because the counter compares against dwell_eff-1.

Timing summary
- Latency from the start edge to the first code is 1 cycle.
- A full non-continuous sweep lasts 4*dwell_eff cycles, and done arrives on cycle 4*dwell_eff+1 after the start edge.

Decomposition:
Shared package decoder_seq_pkg holds:
- the mode constants MODE_UP, MODE_DOWN, MODE_GRAY;
- the state encoding for IDLE and RUN;
- a function code_of(mode, idx) returning the 2-bit code.

Sub-module dwell_timer:
- loadable DWELL_W-bit counter;
- inputs clear/enable/limit, output terminal-count.
- The top level holds the FSM, the idx register and the output registers.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles while start=1 -> all outputs are 0 and the FSM stays in IDLE. Release rst_n -> still idle until the next start.
- Up sweep: mode=00, dwell=3, continuous=0, start pulse at edge 0 ->
  - s=00 on cycles 1-3, 01 on 4-6, 10 on 7-9, 11 on 10-12;
  - step high on cycles 1, 4, 7, 10;
  - done=1 on cycle 13 only, with valid=0 and s=00 on cycle 13.
- Gray and dwell=0: mode=10, dwell=0 -> codes 00, 01, 11, 10 on cycles 1-4, each held 1 cycle; done on cycle 5.
- Continuous with stop: mode=01, dwell=2, continuous=1 ->
  - codes 11, 10, 01, 00 repeat;
  - done and step pulse together on cycle 9, with s=11;
  - stop on cycle 11 -> cycle 12 is IDLE with s=00 and no done.
- Simultaneous events:
  - start and stop together in IDLE -> no sweep starts.
  - stop on the terminal-count cycle of idx=3 -> IDLE and no done.
  - start pulses during RUN -> no effect.
- Latching and dwell limit:
  - change mode and dwell mid-sweep -> the current sweep is unaffected.
  - dwell=255 with DWELL_W=8 -> each code is held exactly 255 cycles.
